// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, ALU op encodings and the ID/EX register layout.
package pipe_pkg;
  localparam int WORD_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [ALUOP_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011
  } aluop_e;
  typedef struct packed {
    logic [WORD_W-1:0]  pc;
    logic [WORD_W-1:0]  rs_val;
    logic [WORD_W-1:0]  rt_val;
    logic [WORD_W-1:0]  imm32;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   wa;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               regwrite;
    logic               memwrite;
    logic               memtoreg;
  } id_ex_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: D-stage fields, M/W forwarding sources and E-stage outputs of the ID/EX stage.
interface id_ex_stage_if;
  import pipe_pkg::*;
  logic               stall, hold;
  logic [WORD_W-1:0]  d_pc, d_rs_val, d_rt_val, d_imm32;
  logic [REG_W-1:0]   d_rs, d_rt, d_wa;
  logic [ALUOP_W-1:0] d_aluop;
  logic               d_alusrc, d_regwrite, d_memwrite, d_memtoreg;
  logic               m_regwrite, w_regwrite;
  logic [REG_W-1:0]   m_wa, w_wa;
  logic [WORD_W-1:0]  m_fwd_data, w_wd;
  logic [WORD_W-1:0]  e_a, e_b, e_rt_fwd, e_pc;
  logic [REG_W-1:0]   e_rs, e_rt, e_wa;
  logic [ALUOP_W-1:0] e_aluop;
  logic               e_regwrite, e_memwrite, e_memtoreg;
  modport master (
    output stall, hold, d_pc, d_rs_val, d_rt_val, d_imm32, d_rs, d_rt, d_wa, d_aluop,
           d_alusrc, d_regwrite, d_memwrite, d_memtoreg,
           m_regwrite, m_wa, m_fwd_data, w_regwrite, w_wa, w_wd,
    input  e_a, e_b, e_rt_fwd, e_pc, e_rs, e_rt, e_wa, e_aluop, e_regwrite, e_memwrite, e_memtoreg
  );
  modport slave (
    input  stall, hold, d_pc, d_rs_val, d_rt_val, d_imm32, d_rs, d_rt, d_wa, d_aluop,
           d_alusrc, d_regwrite, d_memwrite, d_memtoreg,
           m_regwrite, m_wa, m_fwd_data, w_regwrite, w_wa, w_wd,
    output e_a, e_b, e_rt_fwd, e_pc, e_rs, e_rt, e_wa, e_aluop, e_regwrite, e_memwrite, e_memtoreg
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: selects the newest value of one source register, M before W, register 0 never forwarded.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0]  s,
  input  logic [WORD_W-1:0] cap,
  input  logic              m_regwrite,
  input  logic [REG_W-1:0]  m_wa,
  input  logic [WORD_W-1:0] m_fwd_data,
  input  logic              w_regwrite,
  input  logic [REG_W-1:0]  w_wa,
  input  logic [WORD_W-1:0] w_wd,
  output logic [WORD_W-1:0] v
);
  always_comb
    v = (s == REG_ZERO) ? cap :
        (m_regwrite && m_wa == s) ? m_fwd_data :
        (w_regwrite && w_wa == s) ? w_wd : cap;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with bubble/freeze control and E-stage operand forwarding.
// Define FORWARD_EN to build the M/W forwarding muxes and the hold-time operand refresh.
module id_ex_stage
  import pipe_pkg::*;
(
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);
  id_ex_t r, d;
  logic [WORD_W-1:0] rs_fwd, rt_fwd;
  assign d = '{pc: bus.d_pc, rs_val: bus.d_rs_val, rt_val: bus.d_rt_val, imm32: bus.d_imm32,
               rs: bus.d_rs, rt: bus.d_rt, wa: bus.d_wa, aluop: bus.d_aluop,
               alusrc: bus.d_alusrc, regwrite: bus.d_regwrite,
               memwrite: bus.d_memwrite, memtoreg: bus.d_memtoreg};
`ifdef FORWARD_EN
  fwd_mux u_rs (.s(r.rs), .cap(r.rs_val), .m_regwrite(bus.m_regwrite), .m_wa(bus.m_wa),
                .m_fwd_data(bus.m_fwd_data), .w_regwrite(bus.w_regwrite), .w_wa(bus.w_wa),
                .w_wd(bus.w_wd), .v(rs_fwd));
  fwd_mux u_rt (.s(r.rt), .cap(r.rt_val), .m_regwrite(bus.m_regwrite), .m_wa(bus.m_wa),
                .m_fwd_data(bus.m_fwd_data), .w_regwrite(bus.w_regwrite), .w_wa(bus.w_wa),
                .w_wd(bus.w_wd), .v(rt_fwd));
`else
  assign rs_fwd = r.rs_val;
  assign rt_fwd = r.rt_val;
`endif
  // hold refreshes operands with forwarded data so it outlives the M/W producers
  always_ff @(posedge clk or posedge reset)
    if (reset) r <= '0;
    else if (bus.hold) begin
      r.rs_val <= rs_fwd;
      r.rt_val <= rt_fwd;
    end
    else if (bus.stall) r <= '0;
    else r <= d;
  assign bus.e_a        = rs_fwd;
  assign bus.e_rt_fwd   = rt_fwd;
  assign bus.e_b        = r.alusrc ? r.imm32 : rt_fwd;
  assign bus.e_pc       = r.pc;
  assign bus.e_rs       = r.rs;
  assign bus.e_rt       = r.rt;
  assign bus.e_wa       = r.wa;
  assign bus.e_aluop    = r.aluop;
  assign bus.e_regwrite = r.regwrite;
  assign bus.e_memwrite = r.memwrite;
  assign bus.e_memtoreg = r.memtoreg;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS core. It captures decoded instruction fields and register-file operands at the end of D. In E it drives the ALU operands A/B, the store data and the control fields, forwarding results still in flight from M and W. It supports bubble insertion for load-use stalls and a freeze for back-end busy conditions.

## Interface
- Parameters: none. Widths come from the shared package.
- Ports:
- clk  in  1  core clock, rising-edge
- reset  in  1  asynchronous, active-high; clears stage to a bubble
- stall  in  1  load-use hazard; next edge loads a bubble instead of D fields
- hold  in  1  freeze; next edge keeps current E contents (with operand refresh)
- d_pc  in  32  PC of D instruction
- d_rs_val, d_rt_val  in  32 each  GRF read data
- d_imm32  in  32  already-extended immediate
- d_rs, d_rt, d_wa  in  5 each  source and destination register numbers
- d_aluop  in  3  ALU operation
- d_alusrc, d_regwrite, d_memwrite, d_memtoreg  in  1 each  control
- m_regwrite, m_wa, m_fwd_data  in  1/5/32  M-stage forwarding source
- w_regwrite, w_wa, w_wd  in  1/5/32  W-stage forwarding source
- e_a, e_b  out  32 each  ALU operands
- e_rt_fwd  out  32  forwarded rt value, used as store data
- e_pc  out  32; e_rs, e_rt, e_wa  out  5; e_aluop  out  3; e_regwrite, e_memwrite, e_memtoreg  out  1 each

## Operation
- Registered fields: pc, rs_val, rt_val, imm32, rs, rt, wa, aluop, alusrc, regwrite, memwrite, memtoreg.
- Edge priority: reset > hold > stall > normal load.
- Normal load: all fields take the d_* inputs.
- stall: all fields load 0, giving a bubble (regwrite=0, memwrite=0, wa=0, aluop=000).
- hold: control and address fields keep their values. rs_val/rt_val load their current forwarded values (refresh), so forwarded data survives after M/W advance.
- hold and stall together: hold wins and the bubble is dropped. The hazard unit re-asserts stall afterwards.
- Forwarding, per source register s in {rs, rt}:
  - If s==0, use the captured value. Register 0 is never forwarded.
  - Else if m_regwrite && m_wa==s, use m_fwd_data.
  - Else if w_regwrite && w_wa==s, use w_wd.
  - Else use the captured value.
  - M has priority over W.
- Outputs: e_a = rs_fwd; e_rt_fwd = rt_fwd; e_b = alusrc ? imm32 : rt_fwd. No width change; all operands are 32 bits.
- Same-cycle GRF write-then-read for the D instruction is handled inside the GRF, not here.

## Timing
- Latency 1: D fields presented before edge N appear on e_* after edge N.
- e_a/e_b/e_rt_fwd are combinational from the registers plus the M/W inputs in the same cycle. There is no extra cycle for forwarded data.
- Reset (asynchronous assert) drives every registered field to 0, so all outputs are 0 while the M/W inputs are idle.
- Reset deassertion mid-stream: the first edge after reset loads D normally.
- A stall held for k cycles inserts k consecutive bubbles.

## Configuration
- FORWARD_EN defined: forwarding muxes and hold-refresh are present as described.
- FORWARD_EN undefined:
  - e_a = captured rs_val and e_rt_fwd = captured rt_val.
  - hold simply keeps rs_val/rt_val.
  - M/W input ports remain but are ignored. Hazard logic must then stall for all RAW hazards.

## Structure
- Shared package pipe_pkg holds:
  - ALUOp encodings: AND=3'b000, OR=3'b001, ADD=3'b010, SUB=3'b011.
  - Widths: WORD_W=32, REG_W=5, ALUOP_W=3.
  - REG_ZERO=5'd0.
- Sub-module fwd_mux, instantiated twice (rs and rt): inputs reg number, captured value and the M/W sources; output the forwarded value.

## Test plan
- Reset with all d_* set to 32'hFFFFFFFF -> every output 0. After deassert and one edge, outputs equal the d_* values.
- Normal load: d_rs_val=5, d_imm32=7, alusrc=1 -> after edge, e_a=5 and e_b=7. With alusrc=0 and d_rt_val=9 -> e_b=9.
- Forward priority: e_rs=3, m_regwrite=1, m_wa=3, m_fwd_data=100, w_regwrite=1, w_wa=3, w_wd=200 -> e_a=100. With m_regwrite=0 -> e_a=200.
- Register zero: e_rs=0, m_wa=0, m_regwrite=1, m_fwd_data=55 -> e_a equals the captured value, not 55.
- stall=1 for 2 edges -> e_regwrite=0, e_memwrite=0, e_wa=0 for 2 cycles. On the next non-stall edge the pending D instruction loads.
- hold with e_rt=4 and w_wa=4, w_wd=77 on the hold edge; W idle afterwards -> e_rt_fwd stays 77. With hold and stall together, contents are kept rather than bubbled.
